// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction fetch unit
package ifu_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: imem request/response, decode handoff and EXU steering signals
interface ifu_fetch_if
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN = 32
);

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               ifu_valid;
    logic               ifu_ready;
    logic [XLEN-1:0]    ifu_pc;
    logic [INSTR_W-1:0] ifu_instr;
    logic               pc_branch;
    logic [XLEN-1:0]    target_pc;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, ifu_valid, ifu_pc, ifu_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ifu_ready,
               pc_branch, target_pc, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, ifu_valid, ifu_pc, ifu_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, ifu_ready,
               pc_branch, target_pc, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding fetch FSM with branch steering and killable redirect
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master io_fetch
);

    ifu_state_e         r_state, w_state_nxt;
    logic [XLEN-1:0]    r_pc, w_pc_nxt;
    logic [XLEN-1:0]    w_redirect_pc, w_target_pc;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic               r_drop, w_drop_nxt;

    assign w_redirect_pc           = io_fetch.redirect_pc & ~XLEN'(3);
    assign w_target_pc             = io_fetch.target_pc & ~XLEN'(3);
    assign io_fetch.imem_req_valid = !rst && r_state == S_REQ;
    assign io_fetch.imem_req_addr  = r_pc;
    assign io_fetch.ifu_valid      = !rst && r_state == S_HOLD;
    assign io_fetch.ifu_pc         = r_pc;
    assign io_fetch.ifu_instr      = r_instr;

    // Next state, PC and drop flag; a redirect outranks every other event
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            S_REQ: begin
                if (io_fetch.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = io_fetch.redirect_valid;
                end
                if (io_fetch.redirect_valid) w_pc_nxt = w_redirect_pc;
            end
            S_WAIT: begin
                if (io_fetch.imem_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (r_drop || io_fetch.redirect_valid) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_instr_nxt = io_fetch.imem_rsp_data;
                    end
                end else if (io_fetch.redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
                if (io_fetch.redirect_valid) w_pc_nxt = w_redirect_pc;
            end
            S_HOLD: begin
                if (io_fetch.redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (io_fetch.ifu_ready) begin
                    w_pc_nxt    = io_fetch.pc_branch ? w_target_pc : r_pc + XLEN'(4);
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // State registers with synchronous reset to the boot PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scenario tasks with a scoreboard of fetched (pc, instr) pairs
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    logic [63:0] exp_item;
    logic [63:0] sb[$];

    ifu_fetch_if #(.XLEN(32)) bus ();

    ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst(rst),
        .io_fetch(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic clr();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.ifu_ready      = 1'b0;
        bus.pc_branch      = 1'b0;
        bus.target_pc      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        clr();
    endtask

    task automatic to_hold();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word_of(exp_pc);
        sb.push_back({exp_pc, word_of(exp_pc)});
        tick();
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
        checks++; if (bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rst_ifu_valid got=%b exp=0", bus.ifu_valid); end
        rst = 1'b0;
        tick();
        exp_pc = RST_PC;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin failures++; $display("FAIL rst_first_req got=%b/%h exp=1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL seq_req%0d got=%b/%h/%b exp=1/%h/0", i, bus.imem_req_valid, bus.imem_req_addr, bus.ifu_valid, exp_pc); end
            bus.imem_req_ready = 1'b1;
            tick();
            checks++; if (bus.imem_req_valid !== 1'b0 || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got=%b/%b exp=0/0", i, bus.imem_req_valid, bus.ifu_valid); end
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(exp_pc);
            sb.push_back({exp_pc, word_of(exp_pc)});
            tick();
            exp_item = sb.pop_front();
            checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_pc !== exp_item[63:32] || bus.ifu_instr !== exp_item[31:0]) begin failures++; $display("FAIL seq_hold%0d got=%b/%h/%h exp=1/%h/%h", i, bus.ifu_valid, bus.ifu_pc, bus.ifu_instr, exp_item[63:32], exp_item[31:0]); end
            bus.ifu_ready = 1'b1;
            exp_pc = exp_pc + 32'd4;
            tick();
        end
    endtask

    task automatic test_hold();
        to_hold();
        exp_item = sb[0];
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.ifu_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.ifu_pc !== exp_item[63:32] || bus.ifu_instr !== exp_item[31:0]) begin failures++; $display("FAIL hold_stable%0d got=%b/%b/%h/%h exp=1/0/%h/%h", i, bus.ifu_valid, bus.imem_req_valid, bus.ifu_pc, bus.ifu_instr, exp_item[63:32], exp_item[31:0]); end
            tick();
        end
        exp_item = sb.pop_front();
        checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_pc !== exp_item[63:32]) begin failures++; $display("FAIL hold_before_hs got=%b/%h exp=1/%h", bus.ifu_valid, bus.ifu_pc, exp_item[63:32]); end
        bus.ifu_ready = 1'b1;
        exp_pc = exp_pc + 32'd4;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin failures++; $display("FAIL hold_next_req got=%b/%h exp=1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); end
    endtask

    task automatic test_branch();
        to_hold();
        bus.pc_branch = 1'b1;
        bus.target_pc = 32'h8000_0103;
        tick();
        checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_pc !== exp_pc) begin failures++; $display("FAIL br_no_hs got=%b/%h exp=1/%h", bus.ifu_valid, bus.ifu_pc, exp_pc); end
        exp_item = sb.pop_front();
        bus.ifu_ready = 1'b1;
        bus.pc_branch = 1'b1;
        bus.target_pc = 32'h8000_0103;
        exp_pc = 32'h8000_0100;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin failures++; $display("FAIL br_target got=%b/%h exp=1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); end
    endtask

    task automatic test_redirect_wait();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0400;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rdw_still_wait got=%b/%b exp=0/0", bus.imem_req_valid, bus.ifu_valid); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word_of(exp_pc);
        tick();
        exp_pc = 32'h8000_0400;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rdw_refetch got=%b/%h/%b exp=1/%h/0", bus.imem_req_valid, bus.imem_req_addr, bus.ifu_valid, exp_pc); end
    endtask

    task automatic test_redirect_req();
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0803;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rdr_committed got=%b exp=0", bus.imem_req_valid); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word_of(exp_pc);
        tick();
        exp_pc = 32'h8000_0800;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rdr_refetch got=%b/%h/%b exp=1/%h/0", bus.imem_req_valid, bus.imem_req_addr, bus.ifu_valid, exp_pc); end
        to_hold();
        exp_item = sb.pop_front();
        checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_pc !== exp_item[63:32] || bus.ifu_instr !== exp_item[31:0]) begin failures++; $display("FAIL rdr_hold got=%b/%h/%h exp=1/%h/%h", bus.ifu_valid, bus.ifu_pc, bus.ifu_instr, exp_item[63:32], exp_item[31:0]); end
        bus.ifu_ready      = 1'b1;
        bus.pc_branch      = 1'b1;
        bus.target_pc      = 32'h8000_0200;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0C00;
        exp_pc = 32'h8000_0C00;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin failures++; $display("FAIL rdr_over_branch got=%b/%h exp=1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); end
    endtask

    task automatic test_reset_mid();
        bus.imem_req_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rmw_in_rst got=%b/%b exp=0/0", bus.imem_req_valid, bus.ifu_valid); end
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        exp_pc = RST_PC;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rmw_after got=%b/%h/%b exp=1/%h/0", bus.imem_req_valid, bus.imem_req_addr, bus.ifu_valid, exp_pc); end
        to_hold();
        exp_item = sb.pop_front();
        bus.ifu_ready = 1'b1;
        bus.pc_branch = 1'b1;
        bus.target_pc = 32'h8000_0500;
        exp_pc = 32'h8000_0500;
        tick();
        to_hold();
        checks++; if (bus.ifu_valid !== 1'b1 || bus.ifu_pc !== exp_pc) begin failures++; $display("FAIL rmh_hold got=%b/%h exp=1/%h", bus.ifu_valid, bus.ifu_pc, exp_pc); end
        exp_item = sb.pop_front();
        rst = 1'b1;
        tick();
        checks++; if (bus.ifu_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rmh_in_rst got=%b/%b exp=0/0", bus.ifu_valid, bus.imem_req_valid); end
        rst = 1'b0;
        tick();
        exp_pc = RST_PC;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc || bus.ifu_valid !== 1'b0) begin failures++; $display("FAIL rmh_after got=%b/%h/%b exp=1/%h/0", bus.imem_req_valid, bus.imem_req_addr, bus.ifu_valid, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_branch();
        test_redirect_wait();
        test_redirect_req();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit at the front of core_s. It holds the architectural PC, issues one fetch at a time to instruction memory over a valid/ready request channel, and presents the fetched instruction to decode with a valid/ready handshake. It consumes the branch/jump resolution produced by the execution unit (pc_branch, target_pc) to choose the next PC. A separate redirect port (trap entry, mret) can kill the fetch in flight.

Parameters:
XLEN, 32, datapath and PC width.
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_req_addr  out  XLEN  fetch address; always equal to pc register.
imem_rsp_valid  in  1  fetch data returned, one-cycle pulse per accepted request.
imem_rsp_data  in  32  instruction word.
ifu_valid  out  1  instruction available to decode.
ifu_ready  in  1  decode/execute consumes the instruction this cycle.
ifu_pc  out  XLEN  PC of the presented instruction.
ifu_instr  out  32  presented instruction.
pc_branch  in  1  from EXU: the consumed instruction takes a branch/jump.
target_pc  in  XLEN  from EXU: branch/jump target.
redirect_valid  in  1  asynchronous-to-flow redirect (trap/mret), any state.
redirect_pc  in  XLEN  redirect target.

Behaviour:
- State enum: S_REQ, S_WAIT, S_HOLD. Internal regs: pc, instr, state, drop.
- rst high (synchronous): pc<=RESET_PC, state<=S_REQ, drop<=0, instr<=0. While rst high, imem_req_valid=0 and ifu_valid=0 regardless of state.
- S_REQ: imem_req_valid=1, addr=pc. Request is uncommitted until imem_req_ready; address may change while valid&&!ready. imem_req_ready=1 -> S_WAIT.
- S_WAIT: imem_req_valid=0. On imem_rsp_valid: if drop=1, discard data, drop<=0, -> S_REQ; else instr<=imem_rsp_data, -> S_HOLD.
- S_HOLD: ifu_valid=1, ifu_pc=pc, ifu_instr=instr, both stable until handshake. On ifu_valid&&ifu_ready: pc<=pc_branch ? target_pc : pc+4, -> S_REQ. pc_branch/target_pc are sampled only on that handshake cycle; ignored otherwise.
- Redirect (highest priority, any state, not during rst): pc<=redirect_pc.
  S_REQ: stay S_REQ. If imem_req_ready same cycle, request is committed with old address -> S_WAIT with drop<=1.
  S_WAIT: drop<=1 and stay S_WAIT, unless imem_rsp_valid same cycle -> response discarded, S_REQ, drop<=0.
  S_HOLD: instruction killed, -> S_REQ. Redirect overrides a simultaneous ifu_ready/pc_branch handoff.
- Next-PC low bits: target_pc[1:0] and redirect_pc[1:0] forced to 2'b00. pc+4 wraps modulo 2^XLEN.
- Latency: minimum 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD). No backpressure to memory on response. imem_rsp_valid outside S_WAIT is a protocol error and is ignored.
- At most one outstanding request. drop set only when a committed request is outstanding.

Decomposition:
- Shared core package: ifu_state_e enum (S_REQ/S_WAIT/S_HOLD), RESET_PC default constant, INSTR_W=32.
- No sub-module. Next-PC mux and FSM in one module.

Test Plan:
- Reset then zero-wait memory, ifu_ready=1, no branches -> requests at 8000_0000, 8000_0004, 8000_0008, one instruction every 3 cycles, ifu_pc matches.
- HOLD with ifu_ready=0 for 5 cycles -> ifu_valid, ifu_pc, ifu_instr held stable, no new request issued.
- Handshake with pc_branch=1, target_pc=8000_0103 -> next imem_req_addr=8000_0100. pc_branch=1 without handshake -> no effect.
- redirect_valid in S_WAIT (pc_redirect=8000_0400), response 2 cycles later -> response discarded, ifu_valid stays 0, next request at 8000_0400.
- redirect_valid coincident with imem_req_ready in S_REQ -> drop set, returned word discarded, re-fetch from redirect_pc. Redirect coincident with ifu_ready&&pc_branch -> redirect_pc wins.
- rst asserted in S_WAIT and in S_HOLD -> next cycle S_REQ, pc=8000_0000, ifu_valid=0, late imem_rsp_valid ignored.
